// File: rtl/load_store_unit_if.sv
// Request/response handshake and data_memory port bundle for load_store_unit.
// slave = the unit itself; master = pipeline plus memory environment.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [3:0]  mem_write_to;
   logic [31:0] mem_write_value;
   logic [31:0] mem_read_value;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_value,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
             mem_read, mem_write, mem_addr, mem_write_to, mem_write_value
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_value,
      output req_ready, resp_valid, resp_rdata, resp_fault,
             mem_read, mem_write, mem_addr, mem_write_to, mem_write_value
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store sequencer in front of data_memory: one request in flight, lane
// steering and load extension. `define MISALIGNED_SPLIT_EN splits misaligned H/W into two word accesses.
module load_store_unit #(
   parameter int DATA_MEMORY_BITS = 12
) (
   input  logic              clock,
   input  logic              reset,
   load_store_unit_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP} state_t;

   state_t      r_state;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_fault;
   logic        r_mem_read;
   logic        r_mem_write;
   logic [31:0] r_mem_addr;
   logic [3:0]  r_mem_write_to;
   logic [31:0] r_mem_write_value;

   logic        r_write;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;
   logic [29:0] r_word;
   logic        r_fault;
   logic        r_split;

   logic [1:0]  w_off;
   logic [29:0] w_word;
   logic        w_aligned;
   logic        w_bad_code;
   logic        w_fault;
   logic        w_split;
   logic [3:0]  w_size_mask;
   logic [3:0]  w_lanes_lo;
   logic [31:0] w_data_lo;
   logic [31:0] w_raw;
   logic [31:0] w_rdata;

   assign w_off  = bus.req_addr[1:0];
   // Bits above the data_memory decode range pass through untouched.
   assign w_word = {bus.req_addr[31:DATA_MEMORY_BITS], bus.req_addr[DATA_MEMORY_BITS-1:2]};

   assign w_bad_code = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                       (bus.req_write && bus.req_funct3[2]);

   always_comb begin
      w_aligned   = 1'b0;
      w_size_mask = 4'b0000;
      case (bus.req_funct3[1:0])
         2'b00: begin w_aligned = 1'b1;           w_size_mask = 4'b0001; end
         2'b01: begin w_aligned = ~w_off[0];      w_size_mask = 4'b0011; end
         2'b10: begin w_aligned = (w_off == 2'b00); w_size_mask = 4'b1111; end
         default: ;
      endcase
   end

`ifdef MISALIGNED_SPLIT_EN
   logic [7:0]  w_lanes8;
   logic [63:0] w_data64;
   logic [63:0] w_pair;
   logic [3:0]  r_lanes_hi;
   logic [31:0] r_wdata_hi;
   logic [31:0] r_lo_word;

   assign w_fault    = w_bad_code;
   assign w_split    = ~w_bad_code & ~w_aligned;
   assign w_lanes8   = {4'b0000, w_size_mask} << w_off;
   assign w_data64   = {32'h0, bus.req_wdata} << {w_off, 3'b000};
   assign w_lanes_lo = w_lanes8[3:0];
   assign w_data_lo  = w_data64[31:0];
   // Split loads concatenate the two words low-address-first before the lane shift.
   assign w_pair     = r_split ? {bus.mem_read_value, r_lo_word} : {32'h0, bus.mem_read_value};
   assign w_raw      = w_pair[{r_off, 3'b000} +: 32];
`else
   assign w_fault    = w_bad_code | ~w_aligned;
   assign w_split    = 1'b0;
   assign w_lanes_lo = w_size_mask << w_off;
   assign w_data_lo  = bus.req_wdata << {w_off, 3'b000};
   assign w_raw      = bus.mem_read_value >> {r_off, 3'b000};
`endif

   always_comb begin
      case (r_funct3)
         3'b000:  w_rdata = {{24{w_raw[7]}}, w_raw[7:0]};
         3'b001:  w_rdata = {{16{w_raw[15]}}, w_raw[15:0]};
         3'b100:  w_rdata = {24'h0, w_raw[7:0]};
         3'b101:  w_rdata = {16'h0, w_raw[15:0]};
         default: w_rdata = w_raw;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state           <= IDLE;
         r_req_ready       <= 1'b1;
         r_resp_valid      <= 1'b0;
         r_resp_rdata      <= 32'h0;
         r_resp_fault      <= 1'b0;
         r_mem_read        <= 1'b0;
         r_mem_write       <= 1'b0;
         r_mem_addr        <= 32'h0;
         r_mem_write_to    <= 4'h0;
         r_mem_write_value <= 32'h0;
         r_write           <= 1'b0;
         r_funct3          <= 3'b000;
         r_off             <= 2'b00;
         r_word            <= 30'h0;
         r_fault           <= 1'b0;
         r_split           <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
         r_lanes_hi        <= 4'h0;
         r_wdata_hi        <= 32'h0;
         r_lo_word         <= 32'h0;
`endif
      end else begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_write     <= bus.req_write;
                  r_funct3    <= bus.req_funct3;
                  r_off       <= w_off;
                  r_word      <= w_word;
                  r_fault     <= w_fault;
                  r_split     <= w_split;
`ifdef MISALIGNED_SPLIT_EN
                  r_lanes_hi  <= w_lanes8[7:4];
                  r_wdata_hi  <= w_data64[63:32];
`endif
                  r_req_ready <= 1'b0;
                  r_state     <= ACC1;
                  if (!w_fault) begin
                     r_mem_read        <= ~bus.req_write;
                     r_mem_write       <= bus.req_write;
                     r_mem_addr        <= {w_word, 2'b00};
                     r_mem_write_to    <= bus.req_write ? w_lanes_lo : 4'h0;
                     r_mem_write_value <= bus.req_write ? w_data_lo : 32'h0;
                  end
               end
            end
            ACC1: begin
               if (r_fault || (r_write && !r_split)) begin
                  r_resp_valid <= 1'b1;
                  r_resp_fault <= r_fault;
                  r_state      <= RESP;
               end else begin
                  r_state <= WAIT1;
               end
            end
            WAIT1: begin
`ifdef MISALIGNED_SPLIT_EN
               if (r_split) begin
                  r_mem_addr <= {r_word + 30'd1, 2'b00};
                  if (r_write) begin
                     r_mem_write       <= 1'b1;
                     r_mem_write_to    <= r_lanes_hi;
                     r_mem_write_value <= r_wdata_hi;
                  end else begin
                     r_mem_read <= 1'b1;
                     r_lo_word  <= bus.mem_read_value;
                  end
                  r_state <= ACC2;
               end else
`endif
               begin
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_rdata;
                  r_state      <= RESP;
               end
            end
            ACC2: begin
               if (r_write) begin
                  r_resp_valid <= 1'b1;
                  r_state      <= RESP;
               end else begin
                  r_state <= WAIT2;
               end
            end
            WAIT2: begin
               r_resp_valid <= 1'b1;
               r_resp_rdata <= w_rdata;
               r_state      <= RESP;
            end
            RESP: begin
               r_resp_valid <= 1'b0;
               r_resp_rdata <= 32'h0;
               r_resp_fault <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready       = r_req_ready;
   assign bus.resp_valid      = r_resp_valid;
   assign bus.resp_rdata      = r_resp_rdata;
   assign bus.resp_fault      = r_resp_fault;
   assign bus.mem_read        = r_mem_read;
   assign bus.mem_write       = r_mem_write;
   assign bus.mem_addr        = r_mem_addr;
   assign bus.mem_write_to    = r_mem_write_to;
   assign bus.mem_write_value = r_mem_write_value;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequences all stage-4 accesses to data_memory.
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake.
- Converts RV32 funct3 widths into word addresses, byte-lane write enables and lane-shifted store data.
- Formats read data with sign or zero extension and returns one response per request. Stalls the pipeline via req_ready while an access is in flight.

Parameters:
- DATA_MEMORY_BITS, 12, byte-address bits decoded by data_memory. Upper address bits pass through unchanged on mem_addr.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  qualified by resp_valid
- mem_read  out  1  read strobe to data_memory
- mem_write  out  1  write strobe to data_memory
- mem_addr  out  32  word-aligned address; bits [1:0] always 00
- mem_write_to  out  4  lane enables; bit i enables bits [8i+7:8i]
- mem_write_value  out  32  lane-positioned store data
- mem_read_value  in  32  data_memory output; valid the cycle after mem_read

Behaviour:
- Reset values: req_ready=1; all other outputs 0; state IDLE.
- Reset mid-operation: the next edge returns the FSM to IDLE and drops any pending access. A split store whose first half is already written stays partially written.
- Memory-side outputs are registered. mem_read and mem_write each pulse for exactly one cycle per access and are never asserted together.
- FSM states: IDLE, ACC1, WAIT1, ACC2, WAIT2, RESP.
- Acceptance: req_valid && req_ready at rising edge E0. Request fields are latched at E0. req_ready=1 only in IDLE.
- Offset: off = req_addr[1:0].
- Aligned test: B is always aligned; H is aligned when off[0]=0; W is aligned when off=00.
- Invalid requests: funct3 011, 110 or 111, or a store with funct3[2]=1. No memory access. resp_valid=1 and resp_fault=1 in cycle E1–E2, then IDLE.
- Aligned store:
  - E0–E1: mem_write=1, mem_addr={addr[31:2],00}, mem_write_value = wdata<<8*off.
  - mem_write_to: B 0001<<off, H 0011<<off, W 1111.
  - Memory updates at E1. resp_valid high during E1–E2. req_ready high again from E2.
- Aligned load:
  - E0–E1: mem_read=1.
  - E1–E2: WAIT1; the unit samples mem_read_value.
  - E2–E3: resp_valid=1 and resp_rdata = (mem_read_value >> 8*off), truncated to the width then extended. B/H sign-extend; BU/HU/W zero-extend.
  - Next acceptance at E3 at the earliest.
- Back-to-back: a new request is accepted only at an edge where req_ready=1. No request is lost or duplicated if req_valid stays high.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined:
  - Misaligned H/HU/W become two word accesses: ACC1 at word addr[31:2], ACC2 at addr[31:2]+1.
  - First access: lanes n = off..3.
  - Second access: lanes 0..(off+size-5).
  - Store data: first = wdata<<8*off; second = wdata>>8*(4-off).
  - Load: bytes are concatenated low-address-first, then extended.
  - Latency: store response at E3; load response at E4.
  - The word address increment wraps modulo 2^30.
- Undefined: a misaligned H/HU/W is a fault. No memory access; resp_fault=1 at E1.

Test Plan:
- SW 0xDEADBEEF @0x100, then LW @0x100 -> mem_write_to=1111; load resp at E2 = 0xDEADBEEF, fault=0.
- SB 0x000000A5 @0x103, then LB @0x103 and LBU @0x103 -> write_to=1000, write_value=0xA5000000; LB=0xFFFFFFA5, LBU=0x000000A5.
- SH 0x8001 @0x102, then LH and LHU @0x102 -> write_to=1100; LH=0xFFFF8001, LHU=0x00008001.
- LW @0x102 after memory words 0x100=0x44332211 and 0x104=0x88776655:
  - With MISALIGNED_SPLIT_EN: two reads (0x100, 0x104); resp at E4 = 0x66554433.
  - Without it: resp_fault=1 at E1 and no mem strobes.
- funct3=011 load @0x0 -> fault at E1, mem_read never asserted, resp_rdata=0.
- reset asserted during WAIT1 of a load -> next cycle IDLE, req_ready=1, resp_valid never pulses. A following SW/LW pair then behaves as in the first scenario.
